soc_bus_arbiter: RTL and testbench

//  Shares one single-port SoC memory slave (ROM/RAM bus) between three masters:
//  M0 = core load/store, M1 = core instruction fetch, M2 = debug/program loader.

---
 rtl/soc_bus_pkg.sv | 43 ++++
 rtl/soc_bus_arbiter_if.sv | 38 +++
 rtl/arb_rr_picker.sv | 30 +++
 rtl/soc_bus_arbiter.sv | 115 +++++++++++
 tb/tb_soc_bus_arbiter.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/soc_bus_pkg.sv
// Shared constants for the SoC memory bus arbiter: master IDs, FSM encoding, default widths.
package soc_bus_pkg;

  localparam int unsigned NUM_MST = 3;
  localparam int unsigned DEF_AW  = 32;
  localparam int unsigned DEF_DW  = 32;

  typedef logic [1:0] mst_id_t;

  localparam mst_id_t MST_LSU = 2'd0;
  localparam mst_id_t MST_IFU = 2'd1;
  localparam mst_id_t MST_DBG = 2'd2;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } arb_state_e;

  function automatic logic [NUM_MST-1:0] id2oh(input mst_id_t id);
    logic [NUM_MST-1:0] oh;
    oh = '0;
    unique case (id)
      MST_LSU: oh = 3'b001;
      MST_IFU: oh = 3'b010;
      MST_DBG: oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  function automatic mst_id_t oh2id(input logic [NUM_MST-1:0] oh);
    mst_id_t id;
    if (oh[2]) begin
      id = MST_DBG;
    end else if (oh[1]) begin
      id = MST_IFU;
    end else begin
      id = MST_LSU;
    end
    return id;
  endfunction

endpackage

// File: rtl/soc_bus_arbiter_if.sv
// Bus bundle between the three masters, the arbiter and the single-port memory slave.
interface soc_bus_arbiter_if #(
  parameter int unsigned AW = soc_bus_pkg::DEF_AW,
  parameter int unsigned DW = soc_bus_pkg::DEF_DW
);
  logic [2:0]    m_req;
  logic [2:0]    m_we;
  logic [2:0]    m_lock;
  logic [3*AW-1:0] m_addr;
  logic [3*DW-1:0] m_wdata;
  logic [2:0]    m_gnt;
  logic [2:0]    m_rvalid;
  logic [DW-1:0] m_rdata;

  logic          s_req;
  logic          s_we;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic          s_ready;
  logic          s_rvalid;
  logic [DW-1:0] s_rdata;

  modport arbiter (
    input  m_req, m_we, m_lock, m_addr, m_wdata, s_ready, s_rvalid, s_rdata,
    output m_gnt, m_rvalid, m_rdata, s_req, s_we, s_addr, s_wdata
  );

  modport master (
    output m_req, m_we, m_lock, m_addr, m_wdata,
    input  m_gnt, m_rvalid, m_rdata
  );

  modport slave (
    input  s_req, s_we, s_addr, s_wdata,
    output s_ready, s_rvalid, s_rdata
  );

endinterface

// File: rtl/arb_rr_picker.sv
// Three-way priority picker: one-hot start pointer marks the highest-priority requester.
module arb_rr_picker (
  input  logic [2:0] req,
  input  logic [2:0] ptr,
  output logic [2:0] gnt
);

  logic [2:0] rot;
  logic [2:0] pick;

  // Rotate so the pointed-to master sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    rot = '0;
    unique case (ptr)
      3'b001:  rot = req;
      3'b010:  rot = {req[0], req[2:1]};
      3'b100:  rot = {req[1:0], req[2]};
      default: rot = '0;
    endcase
    pick = rot & (~rot + 3'd1);
    gnt  = '0;
    unique case (ptr)
      3'b001:  gnt = pick;
      3'b010:  gnt = {pick[1:0], pick[2]};
      3'b100:  gnt = {pick[0], pick[2:1]};
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/soc_bus_arbiter.sv
// Arbitrates M0 (LSU), M1 (IFU), M2 (debug) onto one memory slave with one outstanding access.
// Define ARB_ROUND_ROBIN_EN for rotating priority; default build is fixed priority M0 > M1 > M2.
module soc_bus_arbiter
  import soc_bus_pkg::*;
#(
  parameter int unsigned AW       = DEF_AW,
  parameter int unsigned DW       = DEF_DW,
  parameter int unsigned LOCK_MAX = 16
) (
  input logic                clk,
  input logic                rst,
  soc_bus_arbiter_if.arbiter bus
);

  localparam int unsigned CW = $clog2(LOCK_MAX + 1);

  arb_state_e        state_q;
  mst_id_t           owner_q;
  logic              lock_mask_q;
  logic [CW-1:0]     lock_cnt_q;
  logic [NUM_MST-1:0] ptr;

`ifdef ARB_ROUND_ROBIN_EN
  logic [NUM_MST-1:0] rr_q;
  assign ptr = rr_q;
`else
  assign ptr = 3'b001;
`endif

  logic [NUM_MST-1:0] owner_oh;
  logic [NUM_MST-1:0] eligible;
  logic [NUM_MST-1:0] win_oh;
  logic               arb_win;
  logic               force_rel;
  logic               owner_drop;
  logic               mask_eff;
  logic               issue;
  logic               win_lock;
  logic [CW-1:0]      cnt_base;
  logic [AW-1:0]      win_addr;
  logic [DW-1:0]      win_wdata;

  assign owner_oh  = id2oh(owner_q);
  assign arb_win   = (state_q == ST_IDLE) || (bus.s_rvalid && (state_q == ST_WAIT));
  assign force_rel = lock_mask_q && (lock_cnt_q == CW'(LOCK_MAX));
  // Only judged at an arbitration point: a locked owner is idle while its access is in flight.
  assign owner_drop = lock_mask_q && arb_win && !(|(bus.m_req & owner_oh));
  assign mask_eff   = lock_mask_q && !force_rel && !owner_drop;
  assign eligible   = mask_eff ? (bus.m_req & owner_oh) : bus.m_req;

  arb_rr_picker u_picker (
    .req (eligible),
    .ptr (ptr),
    .gnt (win_oh)
  );

  assign issue    = !rst && bus.s_ready && arb_win && (|eligible);
  assign win_lock = |(bus.m_lock & win_oh);
  assign cnt_base = mask_eff ? lock_cnt_q : '0;

  always_comb begin
    win_addr  = '0;
    win_wdata = '0;
    for (int i = 0; i < int'(NUM_MST); i++) begin
      if (win_oh[i]) begin
        win_addr  = bus.m_addr[i*AW +: AW];
        win_wdata = bus.m_wdata[i*DW +: DW];
      end
    end
  end

  always_comb begin
    bus.m_gnt    = issue ? win_oh : '0;
    bus.s_req    = issue;
    bus.s_we     = issue && (|(bus.m_we & win_oh));
    bus.s_addr   = issue ? win_addr : '0;
    bus.s_wdata  = issue ? win_wdata : '0;
    bus.m_rvalid = (!rst && bus.s_rvalid && (state_q == ST_WAIT)) ? owner_oh : '0;
    bus.m_rdata  = rst ? '0 : bus.s_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= MST_LSU;
      lock_mask_q <= 1'b0;
      lock_cnt_q  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_q        <= 3'b001;
`endif
    end else if (issue) begin
      state_q <= ST_WAIT;
      owner_q <= oh2id(win_oh);
      if (win_lock) begin
        lock_mask_q <= 1'b1;
        lock_cnt_q  <= cnt_base + CW'(1);
      end else begin
        lock_mask_q <= 1'b0;
        lock_cnt_q  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
        rr_q        <= {win_oh[1:0], win_oh[2]};
`endif
      end
    end else begin
      if (bus.s_rvalid && (state_q == ST_WAIT)) begin
        state_q <= ST_IDLE;
      end
      if (owner_drop) begin
        lock_mask_q <= 1'b0;
        lock_cnt_q  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_soc_bus_arbiter.sv
// Directed bench for soc_bus_arbiter: 1-cycle slave model and a response scoreboard queue.
module tb_soc_bus_arbiter;
  import soc_bus_pkg::*;

  typedef struct {
    logic [2:0]  oh;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;
  exp_t exp_q[$];

  soc_bus_arbiter_if #(.AW(32), .DW(32)) bus ();

  soc_bus_arbiter #(.AW(32), .DW(32), .LOCK_MAX(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] resp_of(input logic [31:0] a);
    return a ^ 32'hDEADBFEF;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock: check grant/slave side and any response, then let the slave answer next cycle.
  task automatic step(input logic [2:0] exp_gnt, input string tag);
    exp_t        e;
    int          w;
    logic        nv;
    logic [31:0] nd;
    @(negedge clk);
    w = exp_gnt[2] ? 2 : (exp_gnt[1] ? 1 : 0);
    check_eq({tag, " gnt"}, 64'(bus.m_gnt), 64'(exp_gnt));
    check_eq({tag, " s_req"}, 64'(bus.s_req), 64'(|exp_gnt));
    if (exp_gnt != 3'b000) begin
      check_eq({tag, " s_addr"}, 64'(bus.s_addr), 64'(bus.m_addr[w*32 +: 32]));
      check_eq({tag, " s_we"}, 64'(bus.s_we), 64'(bus.m_we[w]));
      check_eq({tag, " s_wdata"}, 64'(bus.s_wdata), 64'(bus.m_wdata[w*32 +: 32]));
    end
    if (bus.s_rvalid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq({tag, " rvalid"}, 64'(bus.m_rvalid), 64'(e.oh));
      check_eq({tag, " rdata"}, 64'(bus.m_rdata), 64'(e.data));
    end else begin
      check_eq({tag, " no_rvalid"}, 64'(bus.m_rvalid), 64'(0));
    end
    if (exp_gnt != 3'b000) begin
      e.oh   = exp_gnt;
      e.data = resp_of(bus.m_addr[w*32 +: 32]);
      exp_q.push_back(e);
    end
    nv = bus.s_req;
    nd = resp_of(bus.s_addr);
    @(posedge clk);
    #1;
    bus.s_rvalid = nv;
    bus.s_rdata  = nd;
  endtask

  task automatic do_reset(input string tag);
    rst          = 1'b1;
    bus.m_req    = '0;
    bus.m_we     = '0;
    bus.m_lock   = '0;
    bus.s_ready  = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_eq({tag, " gnt"}, 64'(bus.m_gnt), 64'(0));
    check_eq({tag, " s_req"}, 64'(bus.s_req), 64'(0));
    check_eq({tag, " rvalid"}, 64'(bus.m_rvalid), 64'(0));
    check_eq({tag, " rdata"}, 64'(bus.m_rdata), 64'(0));
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.s_rvalid = 1'b0;
    bus.s_rdata  = '0;
  endtask

  initial begin
    n_checks     = 0;
    n_err        = 0;
    bus.m_req    = '0;
    bus.m_we     = '0;
    bus.m_lock   = '0;
    bus.m_addr   = '0;
    bus.m_wdata  = '0;
    bus.s_ready  = 1'b1;
    bus.s_rvalid = 1'b1;
    bus.s_rdata  = 32'h0BAD_F00D;
    rst          = 1'b1;
    #1;
    bus.m_req = 3'b111;
    do_reset("reset");

    // Lone fetch request
    bus.m_addr[32 +: 32] = 32'h0000_0100;
    bus.m_req            = 3'b010;
    step(3'b010, "t1_grant");
    bus.m_req = 3'b000;
    step(3'b000, "t1_resp");
    check_eq("t1 rdata_abs", 64'(bus.m_rdata), 64'(32'hDEADBEEF));

    // All three request every cycle
    do_reset("t2_reset");
    bus.m_addr  = {32'h0000_0030, 32'h0000_0020, 32'h0000_0010};
    bus.m_wdata = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    bus.m_req   = 3'b111;
    for (int i = 0; i < 6; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      step(3'(3'b001 << (i % 3)), "t2_all");
`else
      step(3'b001, "t2_all");
`endif
    end
    bus.m_req = 3'b000;
    step(3'b000, "t2_drain");

    // Slave stall
    bus.s_ready            = 1'b0;
    bus.m_addr[64 +: 32]   = 32'h0000_0300;
    bus.m_req              = 3'b100;
    for (int i = 0; i < 3; i++) step(3'b000, "t3_stall");
    bus.s_ready = 1'b1;
    step(3'b100, "t3_release");
    bus.m_req = 3'b000;
    step(3'b000, "t3_drain");

    // Lock: 16 consecutive M2 grants, then one M0 grant, then M2 again
    do_reset("t4_reset");
    bus.m_addr  = {32'h0000_0380, 32'h0000_0000, 32'h0000_0040};
    bus.m_req   = 3'b100;
    bus.m_lock  = 3'b100;
    step(3'b100, "t4_lock_first");
    bus.m_req = 3'b101;
    for (int i = 0; i < 15; i++) step(3'b100, "t4_locked");
    step(3'b001, "t4_forced");
    bus.m_req = 3'b100;
    step(3'b100, "t4_relock");
    bus.m_req  = 3'b000;
    bus.m_lock = 3'b000;
    step(3'b000, "t4_drain");

    // Write with ack
    bus.m_addr[0 +: 32]  = 32'h0000_0200;
    bus.m_wdata[0 +: 32] = 32'h1234_5678;
    bus.m_we             = 3'b001;
    bus.m_req            = 3'b001;
    step(3'b001, "t5_write");
    bus.m_req = 3'b000;
    bus.m_we  = 3'b000;
    step(3'b000, "t5_ack");

    // Reset while an access is outstanding
    bus.m_addr[32 +: 32] = 32'h0000_0050;
    bus.m_req            = 3'b010;
    step(3'b010, "t6_grant");
    rst       = 1'b1;
    bus.m_req = 3'b000;
    exp_q.delete();
    @(negedge clk);
    check_eq("t6_rst rvalid", 64'(bus.m_rvalid), 64'(0));
    check_eq("t6_rst gnt", 64'(bus.m_gnt), 64'(0));
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.s_rvalid = 1'b1;
    bus.s_rdata  = 32'hCAFE_0000;
    step(3'b000, "t6_stale");
    bus.m_req = 3'b001;
    step(3'b001, "t6_idle_issue");
    bus.m_req = 3'b000;
    step(3'b000, "t6_drain");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
